// File: rtl/axi4_b_buffer_err.sv
// AXI4 B-channel response buffer with an error-injection port.
// Upstream responses and injected error responses are merged into one in-order FIFO.
module axi4_b_buffer_err #(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4,
    parameter int unsigned BUFFER_DEPTH   = 4,
    parameter int unsigned AFULL_THRESH   = 3,
    parameter logic [1:0]  ERR_RESP       = 2'b10,
    localparam int unsigned CNT_W         = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arstn,

    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_bid,
    input  logic [1:0]                m_axi4_bresp,
    input  logic [AXI_USER_WIDTH-1:0] m_axi4_buser,
    input  logic                      m_axi4_bvalid,
    output logic                      m_axi4_bready,

    input  logic                      inj_valid,
    output logic                      inj_ready,
    input  logic [AXI_ID_WIDTH-1:0]   inj_id,
    input  logic [AXI_USER_WIDTH-1:0] inj_user,

    output logic [AXI_ID_WIDTH-1:0]   s_axi4_bid,
    output logic [1:0]                s_axi4_bresp,
    output logic [AXI_USER_WIDTH-1:0] s_axi4_buser,
    output logic                      s_axi4_bvalid,
    input  logic                      s_axi4_bready,

    output logic [CNT_W-1:0]          fill_o,
    output logic                      afull_o
);

    localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_THRESH);

    typedef struct packed {
        logic [AXI_USER_WIDTH-1:0] user;
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [1:0]                resp;
    } entry_t;

    entry_t           mem_q [BUFFER_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             prio_q, prio_d;
    logic             afull_q, afull_d;

    logic   full;
    logic   push_up;
    logic   push_inj;
    logic   push;
    logic   pop;
    entry_t wr_entry;
    entry_t rd_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full     = (count_q == CNT_FULL);
        // Readies are gated by reset so both stay low while the block is held in reset.
        m_axi4_bready = axi4_arstn && !full && (!inj_valid || !prio_q);
        inj_ready     = axi4_arstn && !full && (!m_axi4_bvalid || prio_q);

        push_up  = m_axi4_bvalid && m_axi4_bready;
        push_inj = inj_valid && inj_ready;
        push     = push_up || push_inj;
        pop      = (count_q != '0) && s_axi4_bready;

        wr_entry = push_inj ? entry_t'{user: inj_user, id: inj_id, resp: ERR_RESP}
                            : entry_t'{user: m_axi4_buser, id: m_axi4_bid, resp: m_axi4_bresp};

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        prio_d = prio_q;
        if (m_axi4_bvalid && inj_valid && !full) begin
            prio_d = ~prio_q;
        end

        afull_d = (count_d >= CNT_AFULL);
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            prio_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
            afull_q  <= afull_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_entry      = mem_q[rd_ptr_q];
    assign s_axi4_bid    = rd_entry.id;
    assign s_axi4_bresp  = rd_entry.resp;
    assign s_axi4_buser  = rd_entry.user;
    assign s_axi4_bvalid = (count_q != '0);
    assign fill_o        = count_q;
    assign afull_o       = afull_q;

endmodule

// File: tb/tb_axi4_b_buffer_err.sv
// Bench for axi4_b_buffer_err: depth-4 and depth-3 instances share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_axi4_b_buffer_err;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       m_bvalid;
    logic [3:0] m_bid;
    logic [1:0] m_bresp;
    logic [3:0] m_buser;
    logic       inj_valid;
    logic [3:0] inj_id;
    logic [3:0] inj_user;
    logic       s_bready;

    logic       m_rdy [2];
    logic       i_rdy [2];
    logic       s_v   [2];
    logic [3:0] s_id  [2];
    logic [1:0] s_rs  [2];
    logic [3:0] s_us  [2];
    logic       af    [2];
    logic [2:0] fill0;
    logic [1:0] fill1;

    axi4_b_buffer_err #(.BUFFER_DEPTH(4), .AFULL_THRESH(3)) u_d4 (
        .axi4_aclk(clk), .axi4_arstn(rst_n),
        .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp), .m_axi4_buser(m_buser),
        .m_axi4_bvalid(m_bvalid), .m_axi4_bready(m_rdy[0]),
        .inj_valid(inj_valid), .inj_ready(i_rdy[0]), .inj_id(inj_id), .inj_user(inj_user),
        .s_axi4_bid(s_id[0]), .s_axi4_bresp(s_rs[0]), .s_axi4_buser(s_us[0]),
        .s_axi4_bvalid(s_v[0]), .s_axi4_bready(s_bready),
        .fill_o(fill0), .afull_o(af[0])
    );

    axi4_b_buffer_err #(.BUFFER_DEPTH(3), .AFULL_THRESH(2)) u_d3 (
        .axi4_aclk(clk), .axi4_arstn(rst_n),
        .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp), .m_axi4_buser(m_buser),
        .m_axi4_bvalid(m_bvalid), .m_axi4_bready(m_rdy[1]),
        .inj_valid(inj_valid), .inj_ready(i_rdy[1]), .inj_id(inj_id), .inj_user(inj_user),
        .s_axi4_bid(s_id[1]), .s_axi4_bresp(s_rs[1]), .s_axi4_buser(s_us[1]),
        .s_axi4_bvalid(s_v[1]), .s_axi4_bready(s_bready),
        .fill_o(fill1), .afull_o(af[1])
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: per-instance queue of {user, id, resp} and arbitration flag.
    logic [9:0] mq [2][$];
    logic       prio [2];
    logic       granted1;
    bit         track;
    logic [3:0] popped [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int depth_of(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int thresh_of(input int i);
        return (i == 0) ? 3 : 2;
    endfunction

    task automatic check_outputs(input int i);
        int          sz;
        bit          full;
        logic [31:0] fill;
        sz   = mq[i].size();
        full = (sz == depth_of(i));
        fill = (i == 0) ? 32'(fill0) : 32'(fill1);
        chk($sformatf("d%0d_mready", i), 32'(m_rdy[i]),
            32'(rst_n && !full && (!inj_valid || !prio[i])));
        chk($sformatf("d%0d_injready", i), 32'(i_rdy[i]),
            32'(rst_n && !full && (!m_bvalid || prio[i])));
        chk($sformatf("d%0d_bvalid", i), 32'(s_v[i]), 32'(sz != 0));
        chk($sformatf("d%0d_fill", i), fill, 32'(sz));
        chk($sformatf("d%0d_afull", i), 32'(af[i]), 32'(sz >= thresh_of(i)));
        if (sz != 0) begin
            chk($sformatf("d%0d_payload", i), 32'({s_us[i], s_id[i], s_rs[i]}), 32'(mq[i][0]));
        end
        if (i == 1 && track && s_v[1] && s_bready) begin
            popped.push_back(s_id[1]);
        end
    endtask

    task automatic model_step(input int i);
        int sz;
        bit full, gu, gi;
        sz   = mq[i].size();
        full = (sz == depth_of(i));
        gu   = m_bvalid && !full && (!inj_valid || !prio[i]);
        gi   = inj_valid && !full && (!m_bvalid || prio[i]);
        if (i == 1) granted1 = gu;
        if (sz != 0 && s_bready) void'(mq[i].pop_front());
        if (gu) mq[i].push_back({m_buser, m_bid, m_bresp});
        if (gi) mq[i].push_back({inj_user, inj_id, 2'b10});
        if (m_bvalid && inj_valid && !full) prio[i] = ~prio[i];
    endtask

    task automatic cycle(input logic mv, input logic [3:0] mid, input logic [1:0] mrs,
                         input logic [3:0] mus, input logic iv, input logic [3:0] iid,
                         input logic [3:0] ius, input logic sr);
        @(negedge clk);
        m_bvalid = mv; m_bid = mid; m_bresp = mrs; m_buser = mus;
        inj_valid = iv; inj_id = iid; inj_user = ius; s_bready = sr;
        #1;
        check_outputs(0);
        check_outputs(1);
        @(posedge clk);
        granted1 = 1'b0;
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
    endtask

    task automatic idle(input int n, input logic sr);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, sr);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            prio[i] = 1'b0;
        end
    endtask

    initial begin
        int k;
        int guard;
        rst_n = 1'b0;
        m_bvalid = 0; m_bid = 0; m_bresp = 0; m_buser = 0;
        inj_valid = 0; inj_id = 0; inj_user = 0; s_bready = 0;
        track = 0; granted1 = 0;
        model_reset();

        // Reset values, including readies held low while valids are high.
        cycle(1, 1, 0, 1, 1, 2, 2, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single upstream push, visible only in the following cycle.
        cycle(1, 3, 0, 5, 0, 0, 0, 1);
        #1;
        chk("basic_bvalid", 32'(s_v[0]), 1);
        chk("basic_id", 32'(s_id[0]), 3);
        chk("basic_user", 32'(s_us[0]), 5);
        idle(1, 1);
        #1;
        chk("basic_drained", 32'(fill0), 0);

        // Contention: grants alternate upstream / injection starting with upstream.
        for (int c = 0; c < 4; c++) cycle(1, 4'(c), 2'b01, 4'(c), 1, 4'(8 + c), 4'(c), 1);
        idle(4, 1);

        // Fill to full with backpressure, then a single pop while upstream stays valid.
        for (int c = 0; c < 4; c++) cycle(1, 4'(c + 4), 2'b00, 4'(c), 0, 0, 0, 0);
        @(negedge clk);
        m_bvalid = 1; s_bready = 0;
        #1;
        chk("full_fill", 32'(fill0), 4);
        chk("full_afull", 32'(af[0]), 1);
        chk("full_mready", 32'(m_rdy[0]), 0);
        chk("full_injready", 32'(i_rdy[0]), 0);
        cycle(1, 4'hc, 0, 0, 0, 0, 0, 1);
        cycle(1, 4'hd, 0, 0, 0, 0, 0, 0);
        #1;
        chk("refill_fill", 32'(fill0), 4);
        idle(6, 1);

        // Simultaneous push and pop at fill 2.
        cycle(1, 1, 0, 1, 0, 0, 0, 0);
        cycle(1, 2, 0, 2, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            cycle(1, 4'(3 + c), 2'b11, 4'(c), 0, 0, 0, 1);
            #1;
            chk("pushpop_fill", 32'(fill0), 2);
        end
        idle(5, 1);

        // Wrap-around on the depth-3 instance: IDs 0..9 under random backpressure.
        track = 1;
        k = 0;
        guard = 0;
        while (k < 10 && guard < 300) begin
            cycle(1, 4'(k), 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
            if (granted1) k++;
            guard++;
        end
        chk("wrap_pushed", 32'(k), 10);
        idle(6, 1);
        track = 0;
        chk("wrap_count", 32'(popped.size()), 10);
        for (int j = 0; j < popped.size() && j < 10; j++) begin
            chk($sformatf("wrap_order%0d", j), 32'(popped[j]), 32'(j));
        end

        // Asynchronous reset with two entries stored.
        cycle(1, 6, 0, 6, 0, 0, 0, 0);
        cycle(1, 7, 0, 7, 0, 0, 0, 0);
        @(negedge clk);
        m_bvalid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bvalid", 32'(s_v[0]), 0);
        chk("arst_fill", 32'(fill0), 0);
        chk("arst_afull", 32'(af[1]), 0);
        chk("arst_mready", 32'(m_rdy[0]), 0);
        model_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 9, 2'b01, 4, 0, 0, 0, 0);
        #1;
        chk("post_rst_id", 32'(s_id[0]), 9);
        chk("post_rst_resp", 32'(s_rs[0]), 1);
        idle(2, 1);

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end
        idle(6, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_b_buffer_err.md
AXI4_B_BUFFER_ERR -- requirements
Module: axi4_b_buffer_err

Interface
REQ-001 Parameter AXI_ID_WIDTH, default 4, width of the B-channel ID field.
REQ-002 Parameter AXI_USER_WIDTH, default 4, width of the B-channel USER field.
REQ-003 Parameter BUFFER_DEPTH, default 4, number of FIFO entries; legal range 2..64, not restricted to powers of two.
REQ-004 Parameter AFULL_THRESH, default 3, fill level at or above which afull_o SHALL assert; legal range 1..BUFFER_DEPTH.
REQ-005 Parameter ERR_RESP, default 2'b10 (SLVERR), BRESP value stored for every injected response.
REQ-006 One clock and one reset: the reset is asynchronous and active-low.
REQ-007 axi4_aclk  in  1  clock; all state changes on the rising edge.
REQ-008 axi4_arstn  in  1  asynchronous active-low reset.
REQ-009 m_axi4_bid / m_axi4_bresp / m_axi4_buser  in  AXI_ID_WIDTH / 2 / AXI_USER_WIDTH  upstream B payload.
REQ-010 m_axi4_bvalid  in  1, m_axi4_bready  out  1: upstream B handshake.
REQ-011 inj_valid  in  1, inj_ready  out  1: error-injection handshake, used by the RAB miss/drop path.
REQ-012 inj_id / inj_user  in  AXI_ID_WIDTH / AXI_USER_WIDTH  payload of the injected response.
REQ-013 s_axi4_bid / s_axi4_bresp / s_axi4_buser  out  AXI_ID_WIDTH / 2 / AXI_USER_WIDTH  downstream B payload.
REQ-014 s_axi4_bvalid  out  1, s_axi4_bready  in  1: downstream B handshake.
REQ-015 fill_o  out  $clog2(BUFFER_DEPTH+1)  current number of stored entries.
REQ-016 afull_o  out  1  high when fill_o >= AFULL_THRESH.

Function
REQ-017 Storage SHALL be a circular FIFO of BUFFER_DEPTH entries {user, id, resp}, with a write pointer, a read pointer and an occupancy counter.
REQ-018 At most one entry SHALL be pushed per cycle.
- Push sources are upstream (m_axi4_bvalid&&m_axi4_bready) or injection (inj_valid&&inj_ready), never both in the same cycle.
REQ-019 Pushes SHALL be accepted only when not full; full is defined as count==BUFFER_DEPTH.
- A pop in the same cycle SHALL NOT free space for a push while full.
REQ-020 Arbitration SHALL use a 1-bit priority flag prio (0=upstream, 1=injection).
- Both valid and not full: the source selected by prio is granted, and prio then toggles.
- Only one source valid: that source is granted, and prio is unchanged.
REQ-021 Ready outputs SHALL be:
- m_axi4_bready = !full && (!inj_valid || prio==0).
- inj_ready = !full && (!m_axi4_bvalid || prio==1).
- Neither ready SHALL depend on its own valid.
REQ-022 An upstream push SHALL store m_axi4_bresp unchanged; an injected push SHALL store resp=ERR_RESP with inj_id and inj_user.
REQ-023 s_axi4_bvalid SHALL equal count!=0, and the s_axi4_b* payload SHALL be driven directly from the entry at the read pointer.
REQ-024 There SHALL be no fall-through path: an entry pushed in cycle N is first visible on s_axi4_b* in cycle N+1.
REQ-025 A pop SHALL occur on s_axi4_bvalid&&s_axi4_bready.
- Payload SHALL stay stable while s_axi4_bvalid=1 and s_axi4_bready=0.
REQ-026 Simultaneous push and pop with 0<count<BUFFER_DEPTH SHALL leave count unchanged and advance both pointers.
REQ-027 Each pointer SHALL wrap from BUFFER_DEPTH-1 to 0, including for non-power-of-two depths.
REQ-028 Entries SHALL leave in push order; no reordering by ID.
REQ-029 fill_o and afull_o SHALL be registered, reflecting the count after the last clock edge.
REQ-030 Pop when empty and push when full SHALL have no effect on state.

Reset
REQ-031 While axi4_arstn=0, pointers, count and prio SHALL be 0.
- Outputs during reset: s_axi4_bvalid=0, fill_o=0, afull_o=0, m_axi4_bready=0, inj_ready=0.
REQ-032 In the first cycle after reset release, m_axi4_bready=1 and inj_ready=1, subject to REQ-021.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries immediately (asynchronously).
REQ-034 Storage array contents need no reset.

Verification
REQ-035 Basic flow, depth 4: push upstream {id=3,resp=0,user=5} in cycle 0 with s_axi4_bready=1 -> s_axi4_bvalid=1 with id=3, resp=0, user=5 in cycle 1 only; fill_o returns to 0.
REQ-036 Fill and backpressure: s_axi4_bready=0, push 4 upstream entries.
- Expected: fill_o=4, afull_o=1 from fill 3 onward, m_axi4_bready=0 and inj_ready=0.
- Then pulse s_axi4_bready=1 for one cycle with m_axi4_bvalid=1 -> no push that cycle; push the following cycle.
REQ-037 Contention: m_axi4_bvalid and inj_valid held high for 4 cycles, s_axi4_bready=1 -> grants alternate upstream, injection, upstream, injection; injected entries carry resp=2'b10.
REQ-038 Wrap-around with BUFFER_DEPTH=3: push/pop 10 entries with IDs 0..9 under random s_axi4_bready -> IDs emerge in order 0..9, with no loss or duplication.
REQ-039 Reset mid-operation: fill_o=2, assert axi4_arstn=0 between clock edges -> s_axi4_bvalid=0 and fill_o=0 immediately; after release the first new push emerges correctly.
REQ-040 Simultaneous push and pop at fill_o=2 for 5 cycles -> fill_o stays 2 and output order is preserved.
